// File: rtl/idecoder_stage_pkg.sv
// rtl/idecoder_stage_pkg.sv - shared widths, opcodes and decode codes for idecoder_stage
package idecoder_stage_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int OPCODE_WIDTH    = 7;
  localparam int INST_TYPE_WIDTH = 4;
  localparam int REG_WIDTH       = 5;
  localparam int FUNCT_WIDTH     = 5;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'h37;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'h17;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'h6F;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'h67;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'h63;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'h03;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'h23;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM = 7'h13;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'h33;

  // Code 0 is reserved: illegal entries carry inst_type = 0.
  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    IT_NONE    = 4'd0,
    IT_LUI     = 4'd1,
    IT_INT_IMM = 4'd2,
    IT_INT_REG = 4'd3,
    IT_JAL     = 4'd4,
    IT_BRANCH  = 4'd5,
    IT_STORE   = 4'd6,
    IT_LOAD    = 4'd7,
    IT_AUIPC   = 4'd8,
    IT_JALR    = 4'd9
  } inst_type_e;

  // Code 0 means "no function" (LUI/AUIPC/JAL/JALR and illegal entries).
  typedef enum logic [FUNCT_WIDTH-1:0] {
    F_NONE       = 5'd0,
    F_ADD        = 5'd1,
    F_SUB        = 5'd2,
    F_SLL        = 5'd3,
    F_SLT        = 5'd4,
    F_SLTU       = 5'd5,
    F_XOR        = 5'd6,
    F_SRL        = 5'd7,
    F_SRA        = 5'd8,
    F_OR         = 5'd9,
    F_AND        = 5'd10,
    F_EQ         = 5'd11,
    F_NEQ        = 5'd12,
    F_LT         = 5'd13,
    F_GTE        = 5'd14,
    F_LTU        = 5'd15,
    F_GTEU       = 5'd16,
    F_MEM_BYTE   = 5'd17,
    F_MEM_HWORD  = 5'd18,
    F_MEM_WORD   = 5'd19,
    F_MEM_BYTEU  = 5'd20,
    F_MEM_HWORDU = 5'd21
  } funct_e;

  // Width-independent part of one decoded buffer entry.
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic [REG_WIDTH-1:0]       rd;
    logic [REG_WIDTH-1:0]       rs1;
    logic [REG_WIDTH-1:0]       rs2;
    logic [FUNCT_WIDTH-1:0]     funct;
    logic                       illegal;
  } dec_fields_t;

endpackage

// File: rtl/idecoder_stage_core.sv
// rtl/idecoder_stage_core.sv - combinational RV32I field decoder (idecode_core)
// Ports:
//   i_inst   - raw 32-bit instruction
//   o_fields - opcode, inst_type, rd/rs1/rs2, funct, illegal
//   o_imm    - immediate, sign-extended to IMM_WIDTH
module idecode_core
  import idecoder_stage_pkg::*;
#(
  parameter int IMM_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] i_inst,
  output dec_fields_t           o_fields,
  output logic [IMM_WIDTH-1:0]  o_imm
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_shamt;
  logic [31:0] w_imm32;
  logic        w_legal;
  dec_fields_t w_raw;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];
  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'h000};
  assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_shamt  = {27'd0, i_inst[24:20]};

  always_comb begin
    w_raw        = '0;
    w_raw.opcode = w_opcode;
    w_imm32      = '0;
    w_legal      = 1'b1;
    case (w_opcode)
      OPC_LUI: begin
        w_raw.inst_type = IT_LUI;
        w_raw.rd        = i_inst[11:7];
        w_imm32         = w_imm_u;
      end
      OPC_AUIPC: begin
        w_raw.inst_type = IT_AUIPC;
        w_raw.rd        = i_inst[11:7];
        w_imm32         = w_imm_u;
      end
      OPC_JAL: begin
        w_raw.inst_type = IT_JAL;
        w_raw.rd        = i_inst[11:7];
        w_imm32         = w_imm_j;
      end
      OPC_JALR: begin
        w_raw.inst_type = IT_JALR;
        w_raw.rd        = i_inst[11:7];
        w_raw.rs1       = i_inst[19:15];
        w_imm32         = w_imm_i;
        w_legal         = (w_funct3 == 3'd0);
      end
      OPC_BRANCH: begin
        w_raw.inst_type = IT_BRANCH;
        w_raw.rs1       = i_inst[19:15];
        w_raw.rs2       = i_inst[24:20];
        w_imm32         = w_imm_b;
        case (w_funct3)
          3'd0:    w_raw.funct = F_EQ;
          3'd1:    w_raw.funct = F_NEQ;
          3'd4:    w_raw.funct = F_LT;
          3'd5:    w_raw.funct = F_GTE;
          3'd6:    w_raw.funct = F_LTU;
          3'd7:    w_raw.funct = F_GTEU;
          default: w_legal     = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_raw.inst_type = IT_LOAD;
        w_raw.rd        = i_inst[11:7];
        w_raw.rs1       = i_inst[19:15];
        w_imm32         = w_imm_i;
        case (w_funct3)
          3'd0:    w_raw.funct = F_MEM_BYTE;
          3'd1:    w_raw.funct = F_MEM_HWORD;
          3'd2:    w_raw.funct = F_MEM_WORD;
          3'd4:    w_raw.funct = F_MEM_BYTEU;
          3'd5:    w_raw.funct = F_MEM_HWORDU;
          default: w_legal     = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_raw.inst_type = IT_STORE;
        w_raw.rs1       = i_inst[19:15];
        w_raw.rs2       = i_inst[24:20];
        w_imm32         = w_imm_s;
        case (w_funct3)
          3'd0:    w_raw.funct = F_MEM_BYTE;
          3'd1:    w_raw.funct = F_MEM_HWORD;
          3'd2:    w_raw.funct = F_MEM_WORD;
          default: w_legal     = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        w_raw.inst_type = IT_INT_IMM;
        w_raw.rd        = i_inst[11:7];
        w_raw.rs1       = i_inst[19:15];
        w_imm32         = w_imm_i;
        case (w_funct3)
          3'd0: w_raw.funct = F_ADD;
          3'd2: w_raw.funct = F_SLT;
          3'd3: w_raw.funct = F_SLTU;
          3'd4: w_raw.funct = F_XOR;
          3'd6: w_raw.funct = F_OR;
          3'd7: w_raw.funct = F_AND;
          // Shift-immediates reuse imm[11:5] as funct7; the immediate is the shamt.
          3'd1: begin
            w_raw.funct = F_SLL;
            w_imm32     = w_shamt;
            w_legal     = (w_funct7 == 7'h00);
          end
          default: begin
            w_imm32 = w_shamt;
            if (w_funct7 == 7'h00)      w_raw.funct = F_SRL;
            else if (w_funct7 == 7'h20) w_raw.funct = F_SRA;
            else                        w_legal     = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        w_raw.inst_type = IT_INT_REG;
        w_raw.rd        = i_inst[11:7];
        w_raw.rs1       = i_inst[19:15];
        w_raw.rs2       = i_inst[24:20];
        if (w_funct7 == 7'h00) begin
          case (w_funct3)
            3'd0:    w_raw.funct = F_ADD;
            3'd1:    w_raw.funct = F_SLL;
            3'd2:    w_raw.funct = F_SLT;
            3'd3:    w_raw.funct = F_SLTU;
            3'd4:    w_raw.funct = F_XOR;
            3'd5:    w_raw.funct = F_SRL;
            3'd6:    w_raw.funct = F_OR;
            default: w_raw.funct = F_AND;
          endcase
        end else if (w_funct7 == 7'h20) begin
          case (w_funct3)
            3'd0:    w_raw.funct = F_SUB;
            3'd5:    w_raw.funct = F_SRA;
            default: w_legal     = 1'b0;
          endcase
        end else begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase
    if (w_opcode[1:0] != 2'b11) w_legal = 1'b0;
  end

  // Illegal instructions keep only the opcode; every other field is zeroed.
  always_comb begin
    o_fields         = '0;
    o_fields.opcode  = w_opcode;
    o_fields.illegal = 1'b1;
    o_imm            = '0;
    if (w_legal) begin
      o_fields         = w_raw;
      o_fields.illegal = 1'b0;
      o_imm            = IMM_WIDTH'($signed(w_imm32));
    end
  end

endmodule

// File: rtl/idecoder_stage.sv
// rtl/idecoder_stage.sv - decode stage with a FIFO of decoded entries between fetch and execute
// Ports:
//   clk, rst                            - clock, asynchronous active-high reset
//   in_valid/in_ready, in_inst, in_pc   - fetch-side handshake and payload
//   flush                               - drop all buffered entries
//   out_valid/out_ready                 - execute-side handshake
//   out_opcode .. out_illegal, out_pc   - head entry, zero while out_valid=0
module idecoder_stage
  import idecoder_stage_pkg::*;
#(
  parameter int IMM_WIDTH = 32,
  parameter int BUF_DEPTH = 2,
  parameter int PC_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_WIDTH-1:0]      in_inst,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPCODE_WIDTH-1:0]    out_opcode,
  output logic [INST_TYPE_WIDTH-1:0] out_inst_type,
  output logic [IMM_WIDTH-1:0]       out_imm,
  output logic [REG_WIDTH-1:0]       out_rd,
  output logic [REG_WIDTH-1:0]       out_rs1,
  output logic [REG_WIDTH-1:0]       out_rs2,
  output logic [FUNCT_WIDTH-1:0]     out_funct,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_illegal
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  dec_fields_t            w_dec_fields;
  logic [IMM_WIDTH-1:0]   w_dec_imm;
  dec_fields_t            w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_out_valid;

  dec_fields_t            r_buf_fields [BUF_DEPTH];
  logic [IMM_WIDTH-1:0]   r_buf_imm    [BUF_DEPTH];
  logic [PC_WIDTH-1:0]    r_buf_pc     [BUF_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  // Holds in_ready low from reset until the first clock edge after release.
  logic                   r_ready_en;

  idecode_core #(
    .IMM_WIDTH (IMM_WIDTH)
  ) u_idecode_core (
    .i_inst   (in_inst),
    .o_fields (w_dec_fields),
    .o_imm    (w_dec_imm)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready    = r_ready_en && (r_count < DEPTH_CNT);
  assign w_out_valid = (r_count != '0);
  assign out_valid   = w_out_valid;
  // flush overrides both handshakes in its cycle.
  assign w_push      = in_valid && in_ready && !flush;
  assign w_pop       = w_out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_en <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_fields[r_wr_ptr] <= w_dec_fields;
      r_buf_imm[r_wr_ptr]    <= w_dec_imm;
      r_buf_pc[r_wr_ptr]     <= in_pc;
    end
  end

  assign w_head = r_buf_fields[r_rd_ptr];

  always_comb begin
    out_opcode    = '0;
    out_inst_type = '0;
    out_imm       = '0;
    out_rd        = '0;
    out_rs1       = '0;
    out_rs2       = '0;
    out_funct     = '0;
    out_pc        = '0;
    out_illegal   = 1'b0;
    if (w_out_valid) begin
      out_opcode    = w_head.opcode;
      out_inst_type = w_head.inst_type;
      out_imm       = r_buf_imm[r_rd_ptr];
      out_rd        = w_head.rd;
      out_rs1       = w_head.rs1;
      out_rs2       = w_head.rs2;
      out_funct     = w_head.funct;
      out_pc        = r_buf_pc[r_rd_ptr];
      out_illegal   = w_head.illegal;
    end
  end

endmodule

// File: tb/tb_idecoder_stage.sv
// tb/tb_idecoder_stage.sv - self-checking bench for idecoder_stage
module tb_idecoder_stage;
  import idecoder_stage_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_opcode;
  logic [3:0]  out_inst_type;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_funct;
  logic [31:0] out_pc;
  logic        out_illegal;

  always #5 clk = ~clk;

  idecoder_stage #(
    .IMM_WIDTH (32),
    .BUF_DEPTH (DEPTH),
    .PC_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_inst_type (out_inst_type),
    .out_imm       (out_imm),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_funct     (out_funct),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal)
  );

  typedef struct packed {
    logic [6:0]  opcode;
    logic [3:0]  itype;
    logic [4:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    exp_t        exp;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input exp_t e);
    chk({tag, "_valid"},   64'(out_valid),     64'(1));
    chk({tag, "_opcode"},  64'(out_opcode),    64'(e.opcode));
    chk({tag, "_type"},    64'(out_inst_type), 64'(e.itype));
    chk({tag, "_funct"},   64'(out_funct),     64'(e.funct));
    chk({tag, "_regs"},    64'({out_rd, out_rs1, out_rs2}), 64'({e.rd, e.rs1, e.rs2}));
    chk({tag, "_imm"},     64'(out_imm),       64'(e.imm));
    chk({tag, "_illegal"}, 64'(out_illegal),   64'(e.illegal));
    chk({tag, "_pc"},      64'(out_pc),        64'(e.pc));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_zero_fields"},
        64'({out_opcode, out_inst_type, out_funct, out_rd, out_rs1, out_rs2, out_illegal}), 64'(0));
    chk({tag, "_zero_imm_pc"}, {out_imm, out_pc}, 64'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Reference decoder: field tables plus integer arithmetic on the immediate slices.
  function automatic exp_t ref_decode(input logic [31:0] x, input logic [31:0] pc);
    exp_t       e;
    logic       ok;
    int         f3;
    int         f7;
    logic [4:0] alu [8];
    logic [4:0] ld  [8];
    logic [4:0] st  [8];
    logic [4:0] br  [8];
    alu = '{F_ADD, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_OR, F_AND};
    ld  = '{F_MEM_BYTE, F_MEM_HWORD, F_MEM_WORD, F_NONE, F_MEM_BYTEU, F_MEM_HWORDU, F_NONE, F_NONE};
    st  = '{F_MEM_BYTE, F_MEM_HWORD, F_MEM_WORD, F_NONE, F_NONE, F_NONE, F_NONE, F_NONE};
    br  = '{F_EQ, F_NEQ, F_NONE, F_NONE, F_LT, F_GTE, F_LTU, F_GTEU};
    f3 = int'(x[14:12]);
    f7 = int'(x[31:25]);
    e = '0;
    e.opcode = x[6:0];
    e.pc = pc;
    ok = 1'b1;
    case (x[6:0])
      7'h37, 7'h17: begin
        e.itype = (x[6:0] == 7'h37) ? IT_LUI : IT_AUIPC;
        e.rd = x[11:7];
        e.imm = int'(x[31:12]) * 4096;
      end
      7'h6F: begin
        e.itype = IT_JAL;
        e.rd = x[11:7];
        e.imm = int'($signed({x[31], x[19:12], x[20], x[30:21]})) * 2;
      end
      7'h67: begin
        ok = (f3 == 0);
        e.itype = IT_JALR;
        e.rd = x[11:7];
        e.rs1 = x[19:15];
        e.imm = int'($signed(x[31:20]));
      end
      7'h63: begin
        e.itype = IT_BRANCH;
        e.funct = br[f3];
        ok = (br[f3] != F_NONE);
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        e.imm = int'($signed({x[31], x[7], x[30:25], x[11:8]})) * 2;
      end
      7'h03: begin
        e.itype = IT_LOAD;
        e.funct = ld[f3];
        ok = (ld[f3] != F_NONE);
        e.rd = x[11:7];
        e.rs1 = x[19:15];
        e.imm = int'($signed(x[31:20]));
      end
      7'h23: begin
        e.itype = IT_STORE;
        e.funct = st[f3];
        ok = (st[f3] != F_NONE);
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        e.imm = int'($signed({x[31:25], x[11:7]}));
      end
      7'h13: begin
        e.itype = IT_INT_IMM;
        e.rd = x[11:7];
        e.rs1 = x[19:15];
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(x[24:20]);
          ok = (f7 == 0) || (f7 == 32 && f3 == 5);
          e.funct = (f7 == 32) ? F_SRA : alu[f3];
        end else begin
          e.imm = int'($signed(x[31:20]));
          e.funct = alu[f3];
        end
      end
      7'h33: begin
        e.itype = IT_INT_REG;
        e.rd = x[11:7];
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.funct = alu[f3];
        if (f7 == 32) e.funct = (f3 == 0) ? F_SUB : F_SRA;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.opcode = x[6:0];
      e.pc = pc;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] x;
    int          sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    x = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) x[6:0] = ops[sel];
    if ($urandom_range(0, 2) != 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
    return x;
  endfunction

  function automatic exp_t mk(input logic [3:0] it, input logic [4:0] fn, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic ill);
    exp_t e;
    e = '0;
    e.itype = it;
    e.funct = fn;
    e.rd = rd;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.imm = imm;
    e.illegal = ill;
    return e;
  endfunction

  vec_t        tab [15];
  exp_t        e;
  exp_t        q [$];
  logic [31:0] got [$];
  logic        push;
  logic        pop;
  logic        sending;

  initial begin
    tab[0]  = '{32'h0080A103, mk(IT_LOAD,    F_MEM_WORD,  2, 1, 0, 32'd8,        1'b0)};
    tab[1]  = '{32'hFE000EE3, mk(IT_BRANCH,  F_EQ,        0, 0, 0, 32'hFFFFFFFC, 1'b0)};
    tab[2]  = '{32'h00000000, mk(IT_NONE,    F_NONE,      0, 0, 0, 32'd0,        1'b1)};
    tab[3]  = '{32'h40001013, mk(IT_NONE,    F_NONE,      0, 0, 0, 32'd0,        1'b1)};
    tab[4]  = '{32'h123452B7, mk(IT_LUI,     F_NONE,      5, 0, 0, 32'h12345000, 1'b0)};
    tab[5]  = '{32'h002081B3, mk(IT_INT_REG, F_ADD,       3, 1, 2, 32'd0,        1'b0)};
    tab[6]  = '{32'h402081B3, mk(IT_INT_REG, F_SUB,       3, 1, 2, 32'd0,        1'b0)};
    tab[7]  = '{32'h40315093, mk(IT_INT_IMM, F_SRA,       1, 2, 0, 32'd3,        1'b0)};
    tab[8]  = '{32'h0020A623, mk(IT_STORE,   F_MEM_WORD,  0, 1, 2, 32'd12,       1'b0)};
    tab[9]  = '{32'h008000EF, mk(IT_JAL,     F_NONE,      1, 0, 0, 32'd8,        1'b0)};
    tab[10] = '{32'hFFF1C203, mk(IT_LOAD,    F_MEM_BYTEU, 4, 3, 0, 32'hFFFFFFFF, 1'b0)};
    tab[11] = '{32'h00002063, mk(IT_NONE,    F_NONE,      0, 0, 0, 32'd0,        1'b1)};
    tab[12] = '{32'h0080A102, mk(IT_NONE,    F_NONE,      0, 0, 0, 32'd0,        1'b1)};
    tab[13] = '{32'hFFFFF097, mk(IT_AUIPC,   F_NONE,      1, 0, 0, 32'hFFFFF000, 1'b0)};
    tab[14] = '{32'hFF8100E7, mk(IT_JALR,    F_NONE,      1, 2, 0, 32'hFFFFFFF8, 1'b0)};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    check_idle("rst");
    rst = 1'b0;
    chk("rel_in_ready_before_edge", 64'(in_ready), 64'(0));
    tick();
    chk("rel_in_ready_after_edge", 64'(in_ready), 64'(1));

    // Table: one push into an empty buffer, visible after one edge, then popped
    for (int i = 0; i < 15; i++) begin
      e = tab[i].exp;
      e.opcode = tab[i].inst[6:0];
      e.pc = 32'h1000 + 32'(i * 4);
      in_valid = 1'b1;
      in_inst = tab[i].inst;
      in_pc = e.pc;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check_head($sformatf("tab%0d", i), e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_idle($sformatf("tab%0d_pop", i));
    end

    // Back-to-back pushes with execute stalled, then drain in order
    in_valid = 1'b1;
    in_inst = tab[0].inst;
    in_pc = 32'h100;
    tick();
    chk("b2b_valid_1", 64'(out_valid), 64'(1));
    chk("b2b_ready_1", 64'(in_ready), 64'(1));
    in_inst = tab[5].inst;
    in_pc = 32'h104;
    tick();
    chk("b2b_full_ready", 64'(in_ready), 64'(0));
    in_inst = tab[7].inst;
    in_pc = 32'h108;
    tick();
    chk("b2b_held_ready", 64'(in_ready), 64'(0));
    chk("b2b_held_head", 64'(out_pc), 64'(32'h100));
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (out_valid) got.push_back(out_pc);
      sending = in_valid && in_ready;
      tick();
      if (sending) in_valid = 1'b0;
    end
    chk("b2b_count", 64'(got.size()), 64'(3));
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("b2b_order%0d", i), 64'(got[i]), 64'(32'h100 + 32'(i * 4)));
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check_idle("b2b_drained");

    // Flush on a full buffer wins over a simultaneous push and pop
    in_valid = 1'b1;
    in_inst = tab[0].inst;
    in_pc = 32'h200;
    tick();
    in_pc = 32'h204;
    tick();
    chk("flush_full", 64'(in_ready), 64'(0));
    in_pc = 32'h208;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_idle("flush_next");
    chk("flush_ready", 64'(in_ready), 64'(1));
    tick();
    tick();
    check_idle("flush_later");
    out_ready = 1'b0;

    // Reset pulse between edges with two entries buffered
    in_valid = 1'b1;
    in_pc = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    in_valid = 1'b0;
    chk("rstmid_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_idle("rstmid_async");
    chk("rstmid_in_ready", 64'(in_ready), 64'(0));
    #1;
    rst = 1'b0;
    chk("rstmid_rel_ready", 64'(in_ready), 64'(0));
    tick();
    chk("rstmid_edge_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_idle($sformatf("rstmid_stale%0d", c));
      tick();
    end

    // Random traffic against a queue model
    do_reset();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      if (q.size() > 0) check_head("rnd", q[0]);
      else              check_idle("rnd_empty");
      in_valid = ($urandom_range(0, 9) < 7);
      in_inst = rand_inst();
      in_pc = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      push = in_valid && (q.size() < DEPTH) && !flush;
      pop = (q.size() > 0) && out_ready && !flush;
      e = ref_decode(in_inst, in_pc);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idecoder_stage.md
IDECODER_STAGE -- requirements
Module: idecoder_stage

Interface
REQ-001 SHALL have parameter IMM_WIDTH, default 32: immediate output width; legal values are 32 and above; immediates are sign-extended to this width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: decoded-entry buffer depth; legal values are 1 and above; any integer is legal, not only powers of 2.
REQ-003 SHALL have parameter PC_WIDTH, default 32: width of the PC carried alongside each instruction.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_inst (input, INST_WIDTH), in_pc (input, PC_WIDTH): fetch-side handshake and payload.
REQ-007 SHALL have port flush, input, 1 bit: discards all buffered entries (taken branch or jump).
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): execute-side handshake.
REQ-009 SHALL have ports out_opcode (OPCODE_WIDTH), out_inst_type (INST_TYPE_WIDTH), out_imm (IMM_WIDTH), out_rd, out_rs1, out_rs2 (REG_WIDTH each), out_funct (FUNCT_WIDTH), out_pc (PC_WIDTH), out_illegal (1), all outputs.

Function
REQ-010 SHALL accept an instruction on a rising edge where in_valid=1 and in_ready=1 and flush=0.
REQ-011 SHALL decode the instruction at accept and store the decoded fields plus in_pc as one buffer entry; raw instructions are never stored.
REQ-012 SHALL drive in_ready = (count < BUF_DEPTH); in_ready has no combinational path from out_ready.
REQ-013 SHALL present the oldest entry on out_*, with out_valid = (count > 0); entries leave in FIFO order.
REQ-014 SHALL pop the head entry on a rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL have a latency of one edge: an instruction accepted into an empty buffer is visible on out_* immediately after that edge.
REQ-016 SHALL support a simultaneous push and pop: count is unchanged and both pointers advance.
REQ-017 SHALL wrap both the read and write pointers from BUF_DEPTH-1 to 0.
REQ-018 SHALL, when flush=1 at an edge, set count to 0 and reset both pointers to 0; a push or pop in that same cycle is ignored (flush wins).
REQ-019 SHALL drive every out_* payload field to 0 while out_valid=0.
REQ-020 SHALL decode LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP to the RV32I immediate formats, sign-extended to IMM_WIDTH.
REQ-021 SHALL map branch funct3 values to EQ, NEQ, LT, GTE, LTU and GTEU.
REQ-022 SHALL map load and store widths to BYTE, HWORD and WORD, and loads additionally to BYTEU and HWORDU.
REQ-023 SHALL map OP and OP-IMM to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND; for OP-IMM shifts, funct7 SHALL select SRL or SRA and imm = shamt.
REQ-024 SHALL set out_illegal=1, with inst_type, funct, rd, rs1, rs2 and imm all 0, for: an unknown opcode, an undefined funct3/funct7 combination, inst[1:0] != 2'b11, or an OP-IMM shift with an illegal funct7.
REQ-025 SHALL pass out_opcode = inst[6:0] for every entry, including illegal ones.

Reset
REQ-026 SHALL, while rst=1, immediately and without a clock edge force count=0, pointers=0, out_valid=0, in_ready=0 and all payload outputs to 0.
REQ-027 SHALL raise in_ready on the first clk edge after rst deasserts.
REQ-028 SHALL discard entries in flight when rst asserts mid-operation; they are never presented.

Structure
REQ-029 SHALL place new INST_TYPE codes (LOAD, AUIPC, JALR) and new FUNCT codes (logic, shift, compare, BYTEU, HWORDU) in the shared copperv header, alongside the existing width macros.
REQ-030 SHALL implement decode as one combinational sub-module, idecode_core (inst in, decoded fields plus illegal out), instantiated at the buffer write port.
REQ-031 SHALL not use a reset on buffer storage arrays; only count, pointers and the output-gating logic are reset.

Verification
REQ-032 SHALL cover: empty buffer, push 0x0080A103 (lw x2,8(x1)) -> after 1 edge out_valid=1, inst_type=LOAD, imm=8, rs1=1, rd=2, funct=MEM_WORD, illegal=0.
REQ-033 SHALL cover: push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, funct=EQ, rs1=rs2=0, rd=0.
REQ-034 SHALL cover: BUF_DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after the second accept and the third instruction held; with out_ready=1 the outputs emerge in order 1, 2, 3.
REQ-035 SHALL cover: buffer full, flush=1 in the same cycle as in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0, and neither the pushed nor the popped entry is observed.
REQ-036 SHALL cover: push 0x00000000 and push 0x40001013 (slli with funct7=0x20) -> both give illegal=1 with inst_type=0 and imm=0.
REQ-037 SHALL cover: two entries buffered, rst pulsed between clock edges -> out_valid=0 and in_ready=0 before the next edge, and no stale entry appears after release.
